// File: rtl/dmem_requester.sv
// Initiator side of the data-memory stall handshake: one load/store at a time.
// Latency: alignment/range fault answers 1 cycle after accept; a memory access answers 5 cycles after accept.
// Backpressure: req_ready is high only in IDLE; req_valid outside IDLE is ignored, nothing is queued.
module dmem_requester #(
  parameter logic [31:0] DATA_BASE  = 32'h1000,
  parameter logic [31:0] DATA_LIMIT = 32'h1FFF,
  parameter logic [31:0] LED_ADDR   = 32'h2000,
  parameter int          TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  // processor request
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  // processor response
  output logic        resp_valid,
  output logic        resp_err,
  output logic [1:0]  resp_cause,
  output logic [31:0] resp_rdata,
  // data memory pins
  output logic [13:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_stall
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT_HI = 3'd2,
    S_WAIT_LO = 3'd3,
    S_RESP    = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  localparam logic [1:0] CAUSE_OK       = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_RANGE    = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  // The wait counter starts at 0 on state entry and counts each cycle spent
  // waiting; the edge that would bring it to TIMEOUT is the one that faults.
  localparam logic [4:0] CNT_LAST = 5'(TIMEOUT - 1);
  localparam logic [4:0] CNT_MAX  = 5'h1F;

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_cnt;
  logic        r_we;

  logic        r_mem_read;
  logic        r_mem_write;
  logic [13:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_sign_mask;

  logic        r_resp_valid;
  logic        r_resp_err;
  logic [1:0]  r_resp_cause;
  logic [31:0] r_resp_rdata;

  logic        w_misaligned;
  logic        w_in_ram;
  logic        w_is_led;
  logic        w_in_range;
  logic [3:0]  w_mask;
  logic [1:0]  w_fault_cause;
  logic        w_cnt_last;
  logic        w_accept;

  assign w_accept   = (r_state == S_IDLE) && req_valid;
  assign w_cnt_last = (r_cnt == CNT_LAST);

  // Alignment check on the incoming request; unsupported widths count as misaligned.
  always_comb begin
    w_misaligned = 1'b0;
    case (req_funct3)
      3'b000, 3'b100: w_misaligned = 1'b0;
      3'b001, 3'b101: w_misaligned = req_addr[0];
      3'b010:         w_misaligned = (req_addr[1:0] != 2'b00);
      default:        w_misaligned = 1'b1;
    endcase
  end

  // Range check: the RAM window, or a word store to the LED register.
  always_comb begin
    w_in_ram   = (req_addr >= DATA_BASE) && (req_addr <= DATA_LIMIT);
    w_is_led   = req_we && (req_funct3 == 3'b010) && (req_addr == LED_ADDR);
    w_in_range = w_in_ram || w_is_led;
  end

  // sign_mask: bit0 always, bit1 half-or-word, bit2 word, bit3 signed load only.
  always_comb begin
    w_mask = 4'b0001;
    case (req_funct3)
      3'b000:  w_mask = {~req_we, 3'b001};
      3'b001:  w_mask = {~req_we, 3'b011};
      3'b010:  w_mask = 4'b0111;
      3'b100:  w_mask = 4'b0001;
      3'b101:  w_mask = 4'b0011;
      default: w_mask = 4'b0001;
    endcase
  end

  // Next-state logic and the fault cause that goes with a FAULT entry.
  always_comb begin
    w_next        = r_state;
    w_fault_cause = CAUSE_OK;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_misaligned) begin
            w_next        = S_FAULT;
            w_fault_cause = CAUSE_MISALIGN;
          end else if (!w_in_range) begin
            w_next        = S_FAULT;
            w_fault_cause = CAUSE_RANGE;
          end else begin
            w_next = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        // A stall already high here is deliberately not sampled.
        w_next = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (mem_stall) begin
          w_next = S_WAIT_LO;
        end else if (w_cnt_last) begin
          w_next        = S_FAULT;
          w_fault_cause = CAUSE_TIMEOUT;
        end
      end
      S_WAIT_LO: begin
        if (!mem_stall) begin
          w_next = S_RESP;
        end else if (w_cnt_last) begin
          w_next        = S_FAULT;
          w_fault_cause = CAUSE_TIMEOUT;
        end
      end
      S_RESP:  w_next = S_IDLE;
      S_FAULT: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Saturating wait counter, cleared whenever a new state is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 5'd0;
    end else if (w_next != r_state) begin
      r_cnt <= 5'd0;
    end else if (r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + 5'd1;
    end
  end

  // Latch the direction of every accepted request, faulted or not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we <= 1'b0;
    end else if (w_accept) begin
      r_we <= req_we;
    end
  end

  // Memory pins: strobes are a single ISSUE-cycle pulse; address, data and
  // mask load only when an access is actually issued and hold until the next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_mem_addr      <= 14'd0;
      r_mem_wdata     <= 32'd0;
      r_mem_sign_mask <= 4'd0;
    end else begin
      r_mem_read  <= (r_state == S_IDLE) && (w_next == S_ISSUE) && !req_we;
      r_mem_write <= (r_state == S_IDLE) && (w_next == S_ISSUE) && req_we;
      if ((r_state == S_IDLE) && (w_next == S_ISSUE)) begin
        r_mem_addr      <= req_addr[13:0];
        r_mem_wdata     <= req_we ? req_wdata : 32'd0;
        r_mem_sign_mask <= w_mask;
      end
    end
  end

  // Response: one-cycle strobe on entry to RESP or FAULT; rdata only for good loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_cause <= CAUSE_OK;
      r_resp_rdata <= 32'd0;
    end else begin
      r_resp_valid <= (w_next == S_RESP) || (w_next == S_FAULT);
      r_resp_err   <= (w_next == S_FAULT);
      r_resp_cause <= (w_next == S_FAULT) ? w_fault_cause : CAUSE_OK;
      r_resp_rdata <= ((w_next == S_RESP) && !r_we) ? mem_rdata : 32'd0;
    end
  end

  assign req_ready     = (r_state == S_IDLE);
  assign mem_read      = r_mem_read;
  assign mem_write     = r_mem_write;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign mem_sign_mask = r_mem_sign_mask;
  assign resp_valid    = r_resp_valid;
  assign resp_err      = r_resp_err;
  assign resp_cause    = r_resp_cause;
  assign resp_rdata    = r_resp_rdata;

endmodule

// File: tb/tb_dmem_requester.sv
// Bench for dmem_requester: a stall-pulse memory model, a response scoreboard,
// and one task per scenario checking data, fault codes, latency and pin activity.
module tb_dmem_requester;

  localparam int T = 16;

  typedef struct packed {
    logic        err;
    logic [1:0]  cause;
    logic [31:0] rdata;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [1:0]  resp_cause;
  logic [31:0] resp_rdata;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read, mem_write;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_rdata;
  logic        mem_stall;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int acc_cyc = 0;

  resp_t exp_q[$];
  resp_t obs_q[$];
  int    obs_cyc_q[$];

  bit          model_en    = 1'b1;
  logic [31:0] model_rdata = 32'd0;
  int          rd_pulses   = 0;
  int          wr_pulses   = 0;
  logic [13:0] seen_addr   = '0;
  logic [31:0] seen_wdata  = '0;
  logic [3:0]  seen_mask   = '0;

  dmem_requester #(
    .DATA_BASE(32'h1000), .DATA_LIMIT(32'h1FFF), .LED_ADDR(32'h2000), .TIMEOUT(T)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_cause(resp_cause),
    .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_sign_mask(mem_sign_mask),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pin monitor: counts strobe cycles and records what was presented with them.
  always @(negedge clk) begin
    if (mem_read)  rd_pulses <= rd_pulses + 1;
    if (mem_write) wr_pulses <= wr_pulses + 1;
    if (mem_read || mem_write) begin
      seen_addr  <= mem_addr;
      seen_wdata <= mem_wdata;
      seen_mask  <= mem_sign_mask;
    end
  end

  // Response monitor: every resp_valid cycle goes into the observed queue.
  always @(negedge clk) begin
    if (resp_valid) begin
      obs_q.push_back({resp_err, resp_cause, resp_rdata});
      obs_cyc_q.push_back(cyc);
    end
  end

  // Memory model: stall rises after the edge that ends the strobe and falls
  // two edges later, i.e. high after E1 and low after E3.
  initial begin
    mem_stall = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if ((mem_read || mem_write) && model_en) begin
        @(posedge clk);
        #1 mem_stall = 1'b1;
        mem_rdata = model_rdata;
        @(posedge clk);
        @(posedge clk);
        #1 mem_stall = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  function automatic resp_t mk(input logic e, input logic [1:0] c, input logic [31:0] d);
    resp_t r;
    r.err = e; r.cause = c; r.rdata = d;
    return r;
  endfunction

  // Present one request for one accept edge and push its expected response.
  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input resp_t exp);
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    req_valid = 1'b0;
  endtask

  // Wait (bounded) for the next response; latency is edges from accept to the
  // edge that raised resp_valid (4 = visible in the 5th cycle after accept).
  task automatic wait_resp(input int budget, output bit got, output resp_t obs,
                           output resp_t exp, output int lat);
    got = 1'b0; obs = 'x; lat = -1;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    for (int i = 0; i < budget && obs_q.size() == 0; i++) @(negedge clk);
    if (obs_q.size() > 0) begin
      got = 1'b1;
      obs = obs_q.pop_front();
      lat = obs_cyc_q.pop_front() - acc_cyc;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'd0; req_wdata = 32'd0;
    #12;
    n_cmp++;
    if ({req_ready, resp_valid, resp_err, resp_cause, resp_rdata} !== {1'b1, 1'b0, 1'b0, 2'b00, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_resp: got rdy=%b v=%b e=%b c=%b d=%h want rdy=1 rest 0",
               req_ready, resp_valid, resp_err, resp_cause, resp_rdata);
    end
    n_cmp++;
    if ({mem_read, mem_write, mem_addr, mem_wdata, mem_sign_mask} !== '0) begin
      n_fail++;
      $display("FAIL reset_mem: got rd=%b wr=%b a=%h d=%h m=%b want all 0",
               mem_read, mem_write, mem_addr, mem_wdata, mem_sign_mask);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_lw;
    bit got; resp_t o, e; int lat; int r0;
    r0 = rd_pulses;
    model_rdata = 32'hDEADBEEF;
    send(1'b0, 3'b010, 32'h1004, 32'd0, mk(1'b0, 2'b00, 32'hDEADBEEF));
    wait_resp(20, got, o, e, lat);
    n_cmp++;
    if (!got || o !== e) begin n_fail++; $display("FAIL lw_resp: got %h want %h", o, e); end
    n_cmp++;
    if (lat !== 4) begin n_fail++; $display("FAIL lw_latency: got %0d want 4", lat); end
    n_cmp++;
    if (rd_pulses - r0 !== 1 || seen_mask !== 4'b0111 || seen_addr !== 14'h1004) begin
      n_fail++;
      $display("FAIL lw_pins: got pulses=%0d mask=%b addr=%h want 1 0111 1004",
               rd_pulses - r0, seen_mask, seen_addr);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_bytes;
    bit got; resp_t o, e; int lat;
    model_rdata = 32'h000000F0;
    send(1'b0, 3'b000, 32'h1003, 32'd0, mk(1'b0, 2'b00, 32'h000000F0));
    wait_resp(20, got, o, e, lat);
    n_cmp++;
    if (!got || o !== e || seen_mask !== 4'b1001 || seen_addr !== 14'h1003) begin
      n_fail++;
      $display("FAIL lb: got resp=%h mask=%b addr=%h want resp=%h mask=1001 addr=1003",
               o, seen_mask, seen_addr, e);
    end
    send(1'b0, 3'b100, 32'h1003, 32'd0, mk(1'b0, 2'b00, 32'h000000F0));
    wait_resp(20, got, o, e, lat);
    n_cmp++;
    if (!got || o !== e || seen_mask !== 4'b0001) begin
      n_fail++;
      $display("FAIL lbu: got resp=%h mask=%b want resp=%h mask=0001", o, seen_mask, e);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_store;
    bit got; resp_t o, e; int lat; int w0, r0;
    w0 = wr_pulses; r0 = rd_pulses;
    model_rdata = 32'hFFFFFFFF;
    send(1'b1, 3'b001, 32'h1002, 32'h1234ABCD, mk(1'b0, 2'b00, 32'd0));
    wait_resp(20, got, o, e, lat);
    n_cmp++;
    if (!got || o !== e || lat !== 4) begin
      n_fail++; $display("FAIL sh_resp: got %h lat %0d want %h lat 4", o, lat, e);
    end
    n_cmp++;
    if (wr_pulses - w0 !== 1 || rd_pulses - r0 !== 0 || seen_wdata !== 32'h1234ABCD || seen_mask !== 4'b0011) begin
      n_fail++;
      $display("FAIL sh_pins: got wr=%0d rd=%0d wdata=%h mask=%b want 1 0 1234abcd 0011",
               wr_pulses - w0, rd_pulses - r0, seen_wdata, seen_mask);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_faults;
    bit got; resp_t o, e; int lat; int r0, w0;
    r0 = rd_pulses; w0 = wr_pulses;
    send(1'b0, 3'b010, 32'h1006, 32'd0, mk(1'b1, 2'b01, 32'd0));
    wait_resp(10, got, o, e, lat);
    n_cmp++;
    if (!got || o !== e || lat !== 0) begin
      n_fail++; $display("FAIL lw_misalign: got %h lat %0d want %h lat 0", o, lat, e);
    end
    send(1'b1, 3'b010, 32'h0800, 32'h5, mk(1'b1, 2'b10, 32'd0));
    wait_resp(10, got, o, e, lat);
    n_cmp++;
    if (!got || o !== e || lat !== 0) begin
      n_fail++; $display("FAIL sw_range: got %h lat %0d want %h lat 0", o, lat, e);
    end
    send(1'b0, 3'b011, 32'h1000, 32'd0, mk(1'b1, 2'b01, 32'd0));
    wait_resp(10, got, o, e, lat);
    n_cmp++;
    if (!got || o !== e) begin n_fail++; $display("FAIL funct3_011: got %h want %h", o, e); end
    send(1'b0, 3'b010, 32'h2000, 32'd0, mk(1'b1, 2'b10, 32'd0));
    wait_resp(10, got, o, e, lat);
    n_cmp++;
    if (!got || o !== e) begin n_fail++; $display("FAIL led_load: got %h want %h", o, e); end
    n_cmp++;
    if (rd_pulses - r0 !== 0 || wr_pulses - w0 !== 0) begin
      n_fail++; $display("FAIL fault_pins: got rd=%0d wr=%0d want 0 0", rd_pulses - r0, wr_pulses - w0);
    end
    w0 = wr_pulses;
    send(1'b1, 3'b010, 32'h2000, 32'h0000_00A5, mk(1'b0, 2'b00, 32'd0));
    wait_resp(20, got, o, e, lat);
    n_cmp++;
    if (!got || o !== e || lat !== 4 || wr_pulses - w0 !== 1 || seen_addr !== 14'h2000) begin
      n_fail++;
      $display("FAIL led_store: got %h lat %0d wr=%0d addr=%h want %h lat 4 wr=1 addr=2000",
               o, lat, wr_pulses - w0, seen_addr, e);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout;
    bit got; resp_t o, e; int lat;
    model_en = 1'b0;
    send(1'b0, 3'b010, 32'h1010, 32'd0, mk(1'b1, 2'b11, 32'd0));
    wait_resp(T + 20, got, o, e, lat);
    n_cmp++;
    if (!got || o !== e) begin n_fail++; $display("FAIL timeout_resp: got %h want %h", o, e); end
    n_cmp++;
    if (lat !== T + 1) begin n_fail++; $display("FAIL timeout_latency: got %0d want %0d", lat, T + 1); end
    model_en = 1'b1;
    repeat (2) @(negedge clk);
    model_rdata = 32'hCAFEF00D;
    send(1'b0, 3'b010, 32'h1010, 32'd0, mk(1'b0, 2'b00, 32'hCAFEF00D));
    wait_resp(20, got, o, e, lat);
    n_cmp++;
    if (!got || o !== e || lat !== 4) begin
      n_fail++; $display("FAIL after_timeout: got %h lat %0d want %h lat 4", o, lat, e);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_access;
    model_rdata = 32'h00000055;
    send(1'b0, 3'b010, 32'h1008, 32'd0, mk(1'b0, 2'b00, 32'h55));
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    // Now in WAIT_LO with stall high.
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    n_cmp++;
    if ({mem_read, mem_write, mem_addr, mem_sign_mask, resp_valid} !== '0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: got rd=%b wr=%b a=%h m=%b v=%b rdy=%b want 0s and rdy=1",
               mem_read, mem_write, mem_addr, mem_sign_mask, resp_valid, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (obs_q.size() !== 0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_after: got resp_count=%0d rdy=%b want 0 and 1", obs_q.size(), req_ready);
    end
    obs_q.delete(); obs_cyc_q.delete();
  endtask

  task automatic test_back_to_back;
    bit got; resp_t o, e; int lat; int r0;
    r0 = rd_pulses;
    model_rdata = 32'h0BADF00D;
    @(negedge clk);
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100C; req_wdata = 32'd0;
    req_valid = 1'b1;
    // Held for 12 edges: accepts land on edges 0 and 6 only.
    exp_q.push_back(mk(1'b0, 2'b00, 32'h0BADF00D));
    exp_q.push_back(mk(1'b0, 2'b00, 32'h0BADF00D));
    repeat (12) @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (obs_q.size() !== 2 || rd_pulses - r0 !== 2) begin
      n_fail++;
      $display("FAIL b2b_count: got resp=%0d reads=%0d want 2 2", obs_q.size(), rd_pulses - r0);
    end
    for (int k = 0; k < 2; k++) begin
      wait_resp(1, got, o, e, lat);
      n_cmp++;
      if (!got || o !== e) begin n_fail++; $display("FAIL b2b_resp%0d: got %h want %h", k, o, e); end
    end
  endtask

  initial begin
    test_reset;
    test_lw;
    test_bytes;
    test_store;
    test_faults;
    test_timeout;
    test_reset_mid_access;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
